// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch slice.
//   fetch_state_t : controller FSM encoding
//   q_entry_t     : one prefetch-queue entry {pc, instruction word}
package fetch_pkg;
    localparam int          INST_W          = 32;
    localparam int          WORD_BYTES      = 4;
    localparam int          ROM_WINDOW_BITS = 8;
    localparam logic [31:0] NOP             = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [INST_W-1:0] pc;
        logic [INST_W-1:0] data;
    } q_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO, QDEPTH entries (power of two).
// Ports:
//   clk, reset_n      : clock, async active-low reset
//   push, push_entry  : write one entry (caller guarantees room, or a pop the same cycle)
//   pop               : consume head (ignored when empty)
//   flush             : empty the queue at the clock edge, overrides push/pop
//   count             : occupancy, log2(QDEPTH)+1 bits
//   head, head_valid  : current head entry and its validity
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int QDEPTH = 2,
    localparam int PW    = $clog2(QDEPTH)
) (
    input  logic      clk,
    input  logic      reset_n,
    input  logic      push,
    input  q_entry_t  push_entry,
    input  logic      pop,
    input  logic      flush,
    output logic [PW:0] count,
    output q_entry_t  head,
    output logic      head_valid
);
    q_entry_t      mem [QDEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_pop;

    assign head_valid = (count != '0);
    assign do_pop     = pop && head_valid;
    assign head       = mem[rd_ptr];

    // Pointers wrap naturally because QDEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)   wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, do_pop};
        end
    end

    // Storage needs no reset: entries are only observed while counted valid.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_entry;
    end
endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer for a combinational 64-word instruction ROM.
// Owns the PC, drives rom_addr, buffers fetched words in fetch_queue and
// hands them to decode over inst_valid/inst_ready.
// Ports:
//   clk, reset_n                  : clock, async active-low reset
//   start, halt                   : leave IDLE / suppress new fetches (levels)
//   rom_addr, rom_data            : ROM address (registered PC) and same-cycle data
//   inst_valid/data/pc, inst_ready: decode handshake on the queue head
//   redirect_valid, redirect_pc   : flush and refetch from a new PC
//   fault, fault_pc               : sticky fetch fault and the PC that caused it
//   busy                          : fetching or queue non-empty
// Optional build macro FETCH_PERF_CNT_EN adds fetch_count / stall_count.
module imem_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [23:0] BASE_ADDRESS = 24'd0,
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          QDEPTH       = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        halt,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_data,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fault,
    output logic [31:0] fault_pc,
    output logic        busy
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count
`endif
);
    localparam int           PW      = $clog2(QDEPTH);
    localparam logic [PW:0]  DEPTH_C = (PW+1)'(QDEPTH);

    fetch_state_t state, state_nx;
    logic [31:0]  pc;
    logic [PW:0]  q_count;
    q_entry_t     head;
    logic         head_valid;
    logic         pop, redir, legal, fetch_try, push;

    assign pop   = head_valid && inst_ready;
    // Redirects are ignored until the controller has been started.
    assign redir = redirect_valid && (state != IDLE);
    assign legal = (pc[1:0] == 2'b00) && (pc[31:ROM_WINDOW_BITS] == BASE_ADDRESS);
    // A pop this cycle frees a slot, so a full queue can still accept a push.
    assign fetch_try = (state == FETCH) && !halt && !redirect_valid &&
                       ((q_count < DEPTH_C) || pop);
    assign push  = fetch_try && legal;

    fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (push),
        .push_entry ('{pc: pc, data: rom_data}),
        .pop        (pop),
        .flush      (redir),
        .count      (q_count),
        .head       (head),
        .head_valid (head_valid)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = FETCH;
            FETCH:   if (fetch_try && !legal) state_nx = FAULT;
            FAULT:   state_nx = FAULT;
            default: state_nx = IDLE;
        endcase
        // An illegal redirect target re-faults on its first fetch attempt.
        if (redir) state_nx = FETCH;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc       <= RESET_PC;
            fault    <= 1'b0;
            fault_pc <= '0;
        end else if (redir) begin
            pc    <= redirect_pc;
            fault <= 1'b0;
        end else begin
            if (push) pc <= pc + 32'(WORD_BYTES);
            if (fetch_try && !legal) begin
                fault    <= 1'b1;
                fault_pc <= pc;
            end
        end
    end

    assign rom_addr   = pc;
    assign inst_valid = head_valid;
    assign inst_data  = head_valid ? head.data : NOP;
    assign inst_pc    = head_valid ? head.pc   : '0;
    assign busy       = (state == FETCH) || (q_count != '0);

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_count <= '0;
            stall_count <= '0;
        end else begin
            if (push && (fetch_count != '1)) fetch_count <= fetch_count + 1'b1;
            if ((state == FETCH) && head_valid && !inst_ready && (stall_count != '1))
                stall_count <= stall_count + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
module tb_imem_fetch_ctrl;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        halt = 1'b0;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        fault;
    logic [31:0] fault_pc;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        if (a[7:2] == 6'd0) return 32'h1804_000A;
        return 32'hC0DE_0000 | {24'h0, a[7:0]};
    endfunction

    assign rom_data = rom_word(rom_addr);

    imem_fetch_ctrl #(.BASE_ADDRESS(24'd0), .RESET_PC(32'h0), .QDEPTH(2)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .halt(halt),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc),
        .inst_ready(inst_ready), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .fault(fault), .fault_pc(fault_pc), .busy(busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0; start = 1'b0; halt = 1'b0; inst_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0;
        sb.delete();
        tick(); tick();
        reset_n = 1'b1;
    endtask

    // Waits (bounded) for a handshake, returns head seen at that negedge, then
    // steps past the edge that consumed it.
    task automatic wait_accept(output logic [31:0] pc, output logic [31:0] data, output bit ok);
        ok = 1'b0; pc = '0; data = '0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (inst_valid === 1'b1 && inst_ready === 1'b1) begin
                pc = inst_pc; data = inst_data; ok = 1'b1;
            end
        end
        tick();
    endtask

    task automatic test_reset();
        logic [31:0] p, d; bit ok; exp_t e;
        reset_n = 1'b0;
        #2;
        n_tests++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", inst_valid); end
        n_tests++; if (inst_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", inst_data); end
        n_tests++; if (inst_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h expected 0", inst_pc); end
        n_tests++; if (fault !== 1'b0 || fault_pc !== 32'h0) begin n_fail++; $display("FAIL reset_fault: got %b/%h expected 0/0", fault, fault_pc); end
        n_tests++; if (busy !== 1'b0 || rom_addr !== 32'h0) begin n_fail++; $display("FAIL reset_busy_addr: got %b/%h expected 0/0", busy, rom_addr); end
        do_reset();
        // redirect while IDLE must be ignored
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        n_tests++; if (rom_addr !== 32'h0 || busy !== 1'b0) begin n_fail++; $display("FAIL idle_redirect: got addr %h busy %b expected 0/0", rom_addr, busy); end
        tick();
        start = 1'b1; inst_ready = 1'b1;
        sb.push_back('{pc: 32'h0, data: 32'h1804_000A});
        wait_accept(p, d, ok);
        e = sb.pop_front();
        n_tests++; if (!ok || p !== e.pc || d !== e.data) begin n_fail++; $display("FAIL idle_redirect_first: got %h/%h ok=%0d expected %h/%h", p, d, ok, e.pc, e.data); end
    endtask

    task automatic test_startup();
        logic [31:0] p, d; bit ok; exp_t e;
        do_reset();
        start = 1'b1; inst_ready = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        n_tests++; if (inst_valid !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL startup_early: got valid %b busy %b expected 0/1", inst_valid, busy); end
        @(negedge clk);
        n_tests++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst_data !== 32'h1804_000A) begin n_fail++; $display("FAIL startup_first: got %b %h %h expected 1 0 1804000a", inst_valid, inst_pc, inst_data); end
        for (int i = 1; i <= 3; i++) sb.push_back('{pc: 32'(4*i), data: rom_word(32'(4*i))});
        while (sb.size() != 0) begin
            wait_accept(p, d, ok);
            e = sb.pop_front();
            n_tests++; if (!ok || p !== e.pc || d !== e.data) begin n_fail++; $display("FAIL startup_seq: got %h/%h ok=%0d expected %h/%h", p, d, ok, e.pc, e.data); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] p, d; bit ok; exp_t e;
        do_reset();
        start = 1'b1; inst_ready = 1'b0;
        repeat (5) tick();
        start = 1'b0;
        @(negedge clk);
        n_tests++; if (rom_addr !== 32'h8 || inst_valid !== 1'b1 || inst_pc !== 32'h0) begin n_fail++; $display("FAIL bp_hold: got addr %h valid %b pc %h expected 8 1 0", rom_addr, inst_valid, inst_pc); end
        tick();
        @(negedge clk);
        n_tests++; if (rom_addr !== 32'h8) begin n_fail++; $display("FAIL bp_frozen: got %h expected 8", rom_addr); end
        tick();
        inst_ready = 1'b1;
        for (int i = 0; i < 4; i++) sb.push_back('{pc: 32'(4*i), data: rom_word(32'(4*i))});
        while (sb.size() != 0) begin
            wait_accept(p, d, ok);
            e = sb.pop_front();
            n_tests++; if (!ok || p !== e.pc || d !== e.data) begin n_fail++; $display("FAIL bp_drain: got %h/%h ok=%0d expected %h/%h", p, d, ok, e.pc, e.data); end
        end
    endtask

    task automatic test_redirect();
        logic [31:0] p, d; bit ok; exp_t e;
        do_reset();
        start = 1'b1; inst_ready = 1'b1;
        repeat (4) wait_accept(p, d, ok);
        start = 1'b0; inst_ready = 1'b0;
        tick(); tick();
        @(negedge clk);
        n_tests++; if (inst_pc !== 32'h10 || rom_addr !== 32'h18) begin n_fail++; $display("FAIL redir_pre: got pc %h addr %h expected 10 18", inst_pc, rom_addr); end
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h28; inst_ready = 1'b1;
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        n_tests++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL redir_flush: got %b expected 0", inst_valid); end
        sb.push_back('{pc: 32'h28, data: rom_word(32'h28)});
        wait_accept(p, d, ok);
        e = sb.pop_front();
        n_tests++; if (!ok || p !== e.pc || d !== e.data) begin n_fail++; $display("FAIL redir_first: got %h/%h ok=%0d expected %h/%h", p, d, ok, e.pc, e.data); end
    endtask

    task automatic test_misaligned();
        logic [31:0] p, d; bit ok; exp_t e;
        do_reset();
        start = 1'b1; inst_ready = 1'b1;
        repeat (3) tick();
        start = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h6;
        tick();
        redirect_valid = 1'b0;
        tick();
        @(negedge clk);
        n_tests++; if (fault !== 1'b1 || fault_pc !== 32'h6) begin n_fail++; $display("FAIL mis_fault: got %b/%h expected 1/6", fault, fault_pc); end
        n_tests++; if (inst_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL mis_nopush: got valid %b busy %b expected 0/0", inst_valid, busy); end
        tick(); tick();
        @(negedge clk);
        n_tests++; if (rom_addr !== 32'h6 || fault !== 1'b1) begin n_fail++; $display("FAIL mis_sticky: got addr %h fault %b expected 6/1", rom_addr, fault); end
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h0;
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        n_tests++; if (fault !== 1'b0) begin n_fail++; $display("FAIL mis_clear: got %b expected 0", fault); end
        sb.push_back('{pc: 32'h0, data: 32'h1804_000A});
        wait_accept(p, d, ok);
        e = sb.pop_front();
        n_tests++; if (!ok || p !== e.pc || d !== e.data) begin n_fail++; $display("FAIL mis_resume: got %h/%h ok=%0d expected %h/%h", p, d, ok, e.pc, e.data); end
    endtask

    task automatic test_window_end();
        logic [31:0] p, d; bit ok; exp_t e;
        do_reset();
        start = 1'b1; inst_ready = 1'b1;
        tick();
        start = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'hFC;
        tick();
        redirect_valid = 1'b0;
        sb.push_back('{pc: 32'hFC, data: rom_word(32'hFC)});
        wait_accept(p, d, ok);
        e = sb.pop_front();
        n_tests++; if (!ok || p !== e.pc || d !== e.data) begin n_fail++; $display("FAIL win_last: got %h/%h ok=%0d expected %h/%h", p, d, ok, e.pc, e.data); end
        @(negedge clk);
        n_tests++; if (fault !== 1'b1 || fault_pc !== 32'h100 || inst_valid !== 1'b0) begin n_fail++; $display("FAIL win_fault: got %b/%h valid %b expected 1/100/0", fault, fault_pc, inst_valid); end
    endtask

    task automatic test_halt_reset();
        logic [31:0] p, d; bit ok; exp_t e;
        do_reset();
        start = 1'b1; inst_ready = 1'b0;
        repeat (5) tick();
        start = 1'b0; halt = 1'b1; inst_ready = 1'b1;
        sb.push_back('{pc: 32'h0, data: rom_word(32'h0)});
        sb.push_back('{pc: 32'h4, data: rom_word(32'h4)});
        while (sb.size() != 0) begin
            wait_accept(p, d, ok);
            e = sb.pop_front();
            n_tests++; if (!ok || p !== e.pc || d !== e.data) begin n_fail++; $display("FAIL halt_drain: got %h/%h ok=%0d expected %h/%h", p, d, ok, e.pc, e.data); end
        end
        @(negedge clk);
        n_tests++; if (inst_valid !== 1'b0 || rom_addr !== 32'h8 || busy !== 1'b1) begin n_fail++; $display("FAIL halt_frozen: got valid %b addr %h busy %b expected 0 8 1", inst_valid, rom_addr, busy); end
        tick();
        halt = 1'b0;
        sb.push_back('{pc: 32'h8, data: rom_word(32'h8)});
        wait_accept(p, d, ok);
        e = sb.pop_front();
        n_tests++; if (!ok || p !== e.pc || d !== e.data) begin n_fail++; $display("FAIL halt_resume: got %h/%h ok=%0d expected %h/%h", p, d, ok, e.pc, e.data); end
        #2;
        reset_n = 1'b0;
        #1;
        n_tests++; if (inst_valid !== 1'b0 || inst_pc !== 32'h0 || inst_data !== 32'h0 || rom_addr !== 32'h0 || busy !== 1'b0 || fault !== 1'b0) begin n_fail++; $display("FAIL async_reset: got valid %b pc %h data %h addr %h busy %b fault %b expected all 0", inst_valid, inst_pc, inst_data, rom_addr, busy, fault); end
        tick();
        reset_n = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        n_tests++; if (busy !== 1'b0 || inst_valid !== 1'b0 || rom_addr !== 32'h0) begin n_fail++; $display("FAIL reset_idle: got busy %b valid %b addr %h expected 0 0 0", busy, inst_valid, rom_addr); end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_backpressure();
        test_redirect();
        test_misaligned();
        test_window_end();
        test_halt_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
- Instruction-fetch sequencer for the pipeline's combinational instruction ROM (32-bit words, 64-word window selected by address[31:8]).
- Owns the PC and drives the ROM address each cycle.
- Buffers fetched words in a small prefetch queue and hands them to decode over a valid/ready handshake.
- Handles redirects (branch/jump), halt, and sticky fetch faults: misaligned target or address outside the ROM window.

Parameters:
BASE_ADDRESS, 24'd0, value that address[31:8] must match for a fetch to be legal
RESET_PC, 32'h0000_0000, PC loaded at reset
QDEPTH, 2, prefetch queue entries (power of two, 2..8)

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
start  input  1  level; leaves IDLE and begins fetching
halt  input  1  level; suppresses new fetches, queue still drains
rom_addr  output  32  address to ROM (registered PC, combinational to ROM)
rom_data  input  32  ROM word for rom_addr, valid same cycle
inst_valid  output  1  queue head valid
inst_data  output  32  queue head instruction
inst_pc  output  32  PC of queue head
inst_ready  input  1  decode accepts head this cycle
redirect_valid  input  1  one-cycle pulse: flush and refetch
redirect_pc  input  32  new PC
fault  output  1  sticky fetch fault
fault_pc  output  32  PC that faulted
busy  output  1  state==FETCH or queue non-empty

Behaviour:
- Reset (async, reset_n low):
  - pc=RESET_PC, queue empty, state=IDLE.
  - inst_valid=0, inst_data=0, inst_pc=0, fault=0, fault_pc=0, busy=0, rom_addr=RESET_PC.
- States:
  - IDLE: start=1 -> FETCH.
  - FETCH: issues fetches.
  - FAULT: no fetches; exits only via reset, or via a redirect to a legal address (-> FETCH, fault cleared).
- Fetch condition (FETCH state):
  - halt=0 and (count<QDEPTH or pop this cycle) and redirect_valid=0.
  - Legality check: legal = (pc[1:0]==0) and (pc[31:8]==BASE_ADDRESS).
- Legal fetch:
  - push {pc, rom_data}; pc<=pc+4.
  - Latency: word fetched in cycle N is visible at inst_valid in cycle N+1.
- Illegal fetch:
  - no push; fault<=1, fault_pc<=pc, state<=FAULT.
  - Already-queued entries remain and drain normally.
- Pop:
  - inst_valid & inst_ready.
  - Simultaneous push+pop when full is allowed; count unchanged.
- Redirect (highest priority, any state except IDLE):
  - A pop in the redirect cycle is honoured; no push that cycle.
  - Queue cleared at the clock edge; pc<=redirect_pc.
  - inst_valid=0 in the following cycle.
  - First new word is valid two cycles after redirect.
  - From FAULT: enter FETCH and clear fault. An illegal target re-faults on the first fetch attempt.
  - Redirect in IDLE is ignored.
- Window end: after the word at offset 63, pc = BASE+256, which faults on the next fetch attempt. There is no wrap-around.
- halt=1: pc frozen, rom_addr stable, queue drains; deassert resumes at the same pc.
- start is ignored outside IDLE.
- Reset asserted mid-operation discards the queue immediately.
- Queue pointers: log2(QDEPTH) bits, wrap modulo QDEPTH; count is log2(QDEPTH)+1 bits.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- When defined:
  - Adds outputs fetch_count[31:0] (legal pushes) and stall_count[31:0].
  - stall_count increments on cycles in FETCH with inst_valid=1 and inst_ready=0.
  - Both counters reset to 0, saturate at 32'hFFFF_FFFF, and are unaffected by redirect.
- When undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package fetch_pkg:
  - state encoding (IDLE=2'd0, FETCH=2'd1, FAULT=2'd2).
  - constants INST_W=32, WORD_BYTES=4, ROM_WINDOW_BITS=8.
  - NOP encoding 32'h0000_0000.
- One sub-module: fetch_queue (parameterised QDEPTH synchronous FIFO; push/pop/flush/count; async active-low reset).

Test Plan:
- Startup fetch: reset, start=1, inst_ready=1, ROM holds 0x1804000A at address 0 -> inst_valid rises 2 cycles after start with inst_pc=0, inst_data=0x1804000A; consecutive PCs are 0,4,8.
- Backpressure: inst_ready=0 for 5 cycles -> queue holds 2 entries (PC 0,4), pc frozen at 8, rom_addr=8; on release, entries are delivered in order with no loss or duplication.
- Redirect: redirect_valid with redirect_pc=0x28 while the queue holds PC 0x10/0x14 -> inst_valid=0 next cycle; the next delivered word has inst_pc=0x28 and data equal to ROM word 10.
- Misaligned redirect: redirect_pc=0x06 -> fault=1, fault_pc=0x06, no push; a later redirect_pc=0x00 clears fault and resumes fetching.
- Window end: redirect_pc=0xFC -> word 63 delivered, then fault=1 with fault_pc=0x100.
- Halt and async reset: halt=1 freezes rom_addr while the queue drains to inst_valid=0; reset_n pulsed low mid-cycle -> all outputs immediately at reset values and state=IDLE.
